// File: rtl/mips16_pkg.sv
// Shared definitions for the LSU memory port: FSM state encoding,
// default bus widths and the word-alignment mask.
package mips16_pkg;

  localparam int LSU_ADDR_W = 16;
  localparam int LSU_DATA_W = 16;

  // Byte-offset bits that must be zero for a word-aligned access.
  localparam logic [1:0] LSU_ALIGN_MASK = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } lsu_state_e;

  // True when the low address bits select a non-word-aligned byte.
  function automatic logic lsu_misaligned(input logic [1:0] addr_lo);
    return ((addr_lo & LSU_ALIGN_MASK) != 2'b00);
  endfunction

endpackage

// File: rtl/lsu_mem_port_if.sv
// CPU request/response and data-memory signals of the LSU memory port.
// slave  : the LSU view (accepts requests, drives memory).
// master : the environment view (CPU plus data memory).
interface lsu_mem_port_if
  import mips16_pkg::*;
#(
  parameter int ADDR_W = LSU_ADDR_W,
  parameter int DATA_W = LSU_DATA_W
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wd;
  logic [DATA_W-1:0] mem_rd;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_rd,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_addr, mem_wd
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_rd,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_addr, mem_wd
  );

endinterface

// File: rtl/lsu_acc_counter.sv
// 16-bit wrapping event counter with an increment enable.
module lsu_acc_counter (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        inc_en,
  output logic [15:0] count
);

  logic [15:0] count_q;
  logic [15:0] count_d;

  // Next count: add one when enabled, natural wrap from 0xFFFF to 0x0000.
  always_comb begin
    count_d = count_q;
    if (inc_en) begin
      count_d = count_q + 16'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= 16'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/lsu_mem_port.sv
// LSU memory port: three-state FSM (IDLE -> ACCESS -> RESP) that turns one
// CPU load/store request into a single data-memory cycle and a held response.
// Optional build macro: LSU_ALIGN_CHECK_EN -- when defined, misaligned
// requests bypass the memory cycle and respond with rsp_err set.
module lsu_mem_port
  import mips16_pkg::*;
#(
  parameter int ADDR_W = LSU_ADDR_W,
  parameter int DATA_W = LSU_DATA_W
) (
  input  logic           clk,
  input  logic           reset_n,
  lsu_mem_port_if.slave  bus,
  output logic [15:0]    acc_count
);

  lsu_state_e        state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              acc_inc_s;

  // Next-state and datapath: latch on accept, sample memory in ACCESS, hold in RESP.
  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wd_d      = wd_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    acc_inc_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          we_d   = bus.req_we;
          addr_d = bus.req_addr;
          wd_d   = bus.req_wdata;
`ifdef LSU_ALIGN_CHECK_EN
          if (lsu_misaligned(bus.req_addr[1:0])) begin
            state_d = ST_RESP;
            err_d   = 1'b1;
            rdata_d = {DATA_W{1'b0}};
          end else begin
            state_d = ST_ACCESS;
          end
`else
          state_d = ST_ACCESS;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        acc_inc_s = 1'b1;
        err_d     = 1'b0;
        rdata_d   = we_q ? {DATA_W{1'b0}} : bus.mem_rd;
        state_d   = ST_RESP;
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any in-flight access.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      addr_q  <= {ADDR_W{1'b0}};
      wd_q    <= {DATA_W{1'b0}};
      rdata_q <= {DATA_W{1'b0}};
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Outputs are decodes of registered state or register values directly.
  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign bus.mem_we    = (state_q == ST_ACCESS) && we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wd    = wd_q;

  lsu_acc_counter u_acc_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .inc_en  (acc_inc_s),
    .count   (acc_count)
  );

endmodule
